// File: rtl/x_chopper_ctrl_if.sv
// Monitored x_chopper input handshake plus the config/hold signals returned to the datapath.
// The master side is the upstream stream source; the slave side is the sequencer.
interface x_chopper_ctrl_if;
    logic        mon_tvalid;
    logic        mon_tready;
    logic        mon_tlast;
    logic [3:0]  mon_tuser;
    logic [15:0] aclk_x_start;
    logic [15:0] aclk_x_size;
    logic [3:0]  aclk_x_scale;
    logic        aclk_x_reverse;
    logic        stream_hold;

    modport master (
        output mon_tvalid, mon_tready, mon_tlast, mon_tuser,
        input  aclk_x_start, aclk_x_size, aclk_x_scale, aclk_x_reverse, stream_hold
    );

    modport slave (
        input  mon_tvalid, mon_tready, mon_tlast, mon_tuser,
        output aclk_x_start, aclk_x_size, aclk_x_scale, aclk_x_reverse, stream_hold
    );
endinterface

// File: rtl/x_chopper_ctrl.sv
// Frame-synchronous ROI config sequencer: validates host updates, applies them between frames (3 cycles in IDLE).
// Backpressure: stream_hold stalls upstream only while an update is being applied between frames.
module x_chopper_ctrl #(
    parameter int MAX_X_SIZE = 4096
) (
    input  logic                aclk,
    input  logic                aclk_reset,
    input  logic [15:0]         reg_x_start,
    input  logic [15:0]         reg_x_size,
    input  logic [3:0]          reg_x_scale,
    input  logic                reg_x_reverse,
    input  logic                reg_update,
    input  logic                err_clr,
    x_chopper_ctrl_if.slave     bus,
    output logic                cfg_busy,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         line_cnt,
    output logic [15:0]         last_frame_lines,
    output logic [2:0]          err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_IN_FRAME
    } state_t;

    state_t      state, state_nxt;
    logic        pending, pending_nxt;
    logic [15:0] stg_start, stg_size;
    logic [3:0]  stg_scale;
    logic        stg_reverse;
    logic [15:0] cfg_start, cfg_size;
    logic [3:0]  cfg_scale;
    logic        cfg_reverse;

    logic        acc, sof, eof, sol, eol;
    logic        in_frame_eff, frame_done, hold;
    logic [16:0] sum;
    logic        cfg_ok, cfg_bad;
    logic [15:0] line_nxt;
    logic [2:0]  err_evt;

    // tlast is deliberately ignored: framing comes from tuser alone.
    logic unused_tlast;
    assign unused_tlast = bus.mon_tlast;

    always_comb begin
        state_nxt    = state;
        acc          = bus.mon_tvalid & bus.mon_tready;
        sof          = acc & bus.mon_tuser[0];
        eof          = acc & bus.mon_tuser[1];
        sol          = acc & bus.mon_tuser[2];
        eol          = acc & bus.mon_tuser[3];
        // A SOF opens the frame before the rest of the same beat is decoded.
        in_frame_eff = (state == S_IN_FRAME) | sof;
        frame_done   = in_frame_eff & eof;
        hold         = ((state == S_IDLE) & pending) | (state == S_LOAD);

        sum     = {1'b0, reg_x_start} + {1'b0, reg_x_size};
        cfg_ok  = reg_update & (reg_x_size != 16'd0) & (sum <= 17'(MAX_X_SIZE));
        cfg_bad = reg_update & ~cfg_ok;

        line_nxt = line_cnt;
        if (sof) begin
            line_nxt = 16'd0;
        end
        if (in_frame_eff & (eol | eof)) begin
            line_nxt = line_nxt + 16'd1;
        end

        err_evt = {acc & hold,
                   (sof & (state == S_IN_FRAME)) | ((sol | eol | eof) & ~in_frame_eff),
                   cfg_bad};

        // A fresh capture in the LOAD cycle re-arms pending for a second LOAD.
        pending_nxt = (pending & (state != S_LOAD)) | cfg_ok;

        if (in_frame_eff) begin
            state_nxt = frame_done ? S_IDLE : S_IN_FRAME;
        end else if ((state == S_IDLE) & pending) begin
            state_nxt = S_LOAD;
        end else begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (aclk_reset) begin
            state            <= S_IDLE;
            pending          <= 1'b0;
            stg_start        <= 16'd0;
            stg_size         <= 16'(MAX_X_SIZE);
            stg_scale        <= 4'd0;
            stg_reverse      <= 1'b0;
            cfg_start        <= 16'd0;
            cfg_size         <= 16'(MAX_X_SIZE);
            cfg_scale        <= 4'd0;
            cfg_reverse      <= 1'b0;
            frame_cnt        <= 16'd0;
            line_cnt         <= 16'd0;
            last_frame_lines <= 16'd0;
            err              <= 3'd0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (state == S_LOAD) begin
                cfg_start   <= stg_start;
                cfg_size    <= stg_size;
                cfg_scale   <= stg_scale;
                cfg_reverse <= stg_reverse;
            end
            if (cfg_ok) begin
                stg_start   <= reg_x_start;
                stg_size    <= reg_x_size;
                stg_scale   <= reg_x_scale;
                stg_reverse <= reg_x_reverse;
            end
            line_cnt <= line_nxt;
            if (frame_done) begin
                last_frame_lines <= line_nxt;
                frame_cnt        <= frame_cnt + 16'd1;
            end
            err <= (err_clr ? 3'd0 : err) | err_evt;
        end
    end

    assign bus.aclk_x_start   = cfg_start;
    assign bus.aclk_x_size    = cfg_size;
    assign bus.aclk_x_scale   = cfg_scale;
    assign bus.aclk_x_reverse = cfg_reverse;
    assign bus.stream_hold    = hold;
    assign cfg_busy           = pending;

endmodule

// File: doc/x_chopper_ctrl.md
# x_chopper_ctrl

Frame-synchronous configuration sequencer for `x_chopper`, on the `aclk` input side. It captures host ROI settings (`x_start`, `x_size`, `x_scale`, `x_reverse`) and validates them. Validated settings are applied only in the gap between frames, so the chopper never sees a mid-frame change. It monitors the chopper's input AXI-Stream handshake to track frame and line boundaries, count lines and frames, and flag sync-protocol errors.

## Interface
- MAX_X_SIZE, 4096, widest legal line in pixels; `x_start + x_size` must not exceed it
- aclk  in  1  sole clock
- aclk_reset  in  1  synchronous, active-high reset
- reg_x_start  in  16  host ROI start pixel
- reg_x_size  in  16  host ROI width in pixels
- reg_x_scale  in  4  host scale code
- reg_x_reverse  in  1  host line-reversal enable
- reg_update  in  1  one-cycle pulse: capture `reg_*` now
- err_clr  in  1  one-cycle pulse: clear `err[2:0]`
- mon_tvalid, mon_tready, mon_tlast  in  1 each  copy of the `x_chopper` input handshake
- mon_tuser  in  4  sync flags: [0]=SOF, [1]=EOF, [2]=SOL, [3]=EOL
- aclk_x_start, aclk_x_size, aclk_x_scale, aclk_x_reverse  out  16/16/4/1  config driven into `x_chopper`
- stream_hold  out  1  upstream ANDs its `tready` with `~stream_hold`
- cfg_busy  out  1  validated update pending, not yet applied
- frame_cnt  out  16  completed frames, wraps modulo 2^16
- line_cnt  out  16  lines completed in the current frame
- last_frame_lines  out  16  `line_cnt` latched at EOF
- err  out  3  sticky: [0] cfg rejected, [1] sync error, [2] handshake during hold

## Operation
- Beat accepted (`acc`) = `mon_tvalid & mon_tready`.
- States and transitions:
  - IDLE: between frames.
  - IDLE → LOAD when pending=1.
  - IDLE → IN_FRAME on an `acc` with SOF.
  - LOAD: exactly one cycle; copies staging into the `aclk_x_*` outputs, clears pending, then → IDLE.
  - IN_FRAME → IDLE on an `acc` with EOF.
- Capture on `reg_update`:
  - Compute `sum = reg_x_start + reg_x_size` at 17 bits (no overflow).
  - Valid iff `reg_x_size != 0` and `sum <= MAX_X_SIZE`.
  - Valid: write staging registers and set pending.
  - Invalid: set err[0]; leave staging and pending unchanged.
- Repeated `reg_update` while pending: the latest valid capture overwrites staging; one LOAD applies it.
- `reg_update` in the LOAD cycle: processed normally. Pending is set again, since set wins over clear, and a second LOAD follows.
- `stream_hold = (state==IDLE & pending) | (state==LOAD)`. It is never asserted in IN_FRAME.
- A pending update raised in IN_FRAME waits. `cfg_busy` stays 1 until the EOF beat and the following LOAD.
- Line counter:
  - `line_cnt` → 0 on an `acc` with SOF.
  - `line_cnt` +1 on an `acc` with EOL or EOF.
  - On EOF: `last_frame_lines ← line_cnt+1` and `frame_cnt` +1 (wraps 0xFFFF→0).
- Sync errors, set err[1] for:
  - SOF accepted in IN_FRAME: treated as a restart; `line_cnt` → 0 and state stays IN_FRAME.
  - SOL, EOL or EOF accepted in IDLE or LOAD: ignored for counters and state.
- Hold violation: an `acc` while `stream_hold=1` sets err[2]. The beat is still decoded normally.
- Error clearing: `err_clr` clears all bits. An error event in the same cycle wins, so that bit stays set.
- `mon_tlast` is not used for sequencing; only `tuser` is decoded.

## Timing
- All outputs are registered, except `stream_hold` (decoded from registers only, glitch-free relative to `aclk`).
- Reset values (`aclk_reset`=1 at a rising edge):
  - state IDLE, pending 0
  - `aclk_x_start`=0, `aclk_x_size`=MAX_X_SIZE, `aclk_x_scale`=0, `aclk_x_reverse`=0
  - counters 0, `err`=0, `stream_hold`=0, `cfg_busy`=0
- Reset mid-frame aborts tracking; the next SOF is accepted without error.
- Update latency, with `reg_update` at edge N while in IDLE:
  - pending, `cfg_busy` and `stream_hold` = 1 after N+1.
  - LOAD after N+2.
  - New `aclk_x_*` visible, `cfg_busy`=0 and `stream_hold`=0 after N+3.
  - Total: 3 cycles, of which 2 are hold.
- Counters and `err` update one cycle after the triggering `acc`.
- `cfg_busy` is the registered pending flag.

## Test plan
- Reset → outputs at reset values; `reg_update` with start=12, size=116 in IDLE → `aclk_x_start`=12, `aclk_x_size`=116 exactly 3 cycles later; `stream_hold` high for exactly 2 cycles.
- Update to start=0, size=64 issued mid-line of a 4-line, 128-beat-per-line frame → config unchanged until EOF accepted, then LOAD; `frame_cnt`=1, `last_frame_lines`=4.
- `reg_update` with start=4000, size=200 (sum 4200 > 4096), and separately size=0 → err[0]=1, config and `cfg_busy` unchanged; `err_clr` → err=0.
- Two SOFs with no EOF in between → err[1]=1 and `line_cnt` restarts at 0; EOL beat while IDLE → err[1], `line_cnt` unchanged.
- Force `mon_tready`=1 during hold with an SOF beat → err[2]=1 and state → IN_FRAME.
- 65536 frames of 1 line each → `frame_cnt` wraps to 0; `aclk_reset` asserted mid-frame → all outputs at reset values next cycle.
